// File: rtl/regfile_bypass_sb.sv
// ============================================================================
// Module   : regfile_bypass_sb
// Brief    : 2R/2W register file with same-cycle write bypass, busy scoreboard
//            and a post-reset sequential clearing sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr
);

    localparam int                c_NREGS    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_PTR_LAST = '1;
    localparam logic [0:0]        c_S_INIT   = 1'b0;
    localparam logic [0:0]        c_S_RUN    = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [ADDR_W-1:0]       r_ptr;
    logic [DATA_W-1:0]       r_regs [c_NREGS];
    logic [c_NREGS-1:0]      r_busy;
    logic [c_NREGS-1:0]      w_busy_nxt;
    logic                    w_run;
    logic                    w_wr0_ok;
    logic                    w_wr1_ok;
    logic                    w_iss_ok;
    logic [1:0][ADDR_W-1:0]  w_raddr;
    logic [1:0][DATA_W-1:0]  w_rdata;
    logic [1:0]              w_rbusy;

    function automatic logic f_is_r0(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_INIT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_S_INIT && r_ptr == c_PTR_LAST)
            w_state_nxt = c_S_RUN;
    end

    always_comb begin
        w_run = (r_state == c_S_RUN);
        ready = w_run;
    end

    always_ff @(posedge clk) begin
        if (rst)                       r_ptr <= '0;
        else if (r_state == c_S_INIT)  r_ptr <= r_ptr + ADDR_W'(1);
    end

    // Hardwired r0 swallows writes and issues entirely, so it never goes busy.
    assign w_wr0_ok = w_run && wr0_en && !f_is_r0(wr0_addr);
    assign w_wr1_ok = w_run && wr1_en && !f_is_r0(wr1_addr);
    assign w_iss_ok = w_run && iss_en && !f_is_r0(iss_addr);

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_S_INIT) begin
                r_regs[r_ptr] <= '0;
            end else begin
                if (w_wr0_ok) r_regs[wr0_addr] <= wr0_data;
                if (w_wr1_ok) r_regs[wr1_addr] <= wr1_data;
            end
        end
    end

    // ---------------- scoreboard ----------------
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0_ok) w_busy_nxt[wr0_addr] = 1'b0;
        if (w_wr1_ok) w_busy_nxt[wr1_addr] = 1'b0;
        // Issue applied last: a new producer outranks a retiring one.
        if (w_iss_ok) w_busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    // ---------------- read ports ----------------
    assign w_raddr = {rd_addr_b, rd_addr_a};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_hit0;
        logic w_hit1;
        logic w_live;

        assign w_hit0 = w_wr0_ok && (wr0_addr == w_raddr[p]);
        assign w_hit1 = w_wr1_ok && (wr1_addr == w_raddr[p]);
        assign w_live = w_run && !f_is_r0(w_raddr[p]);

        assign w_rdata[p] = !w_live ? '0       :
                            w_hit1  ? wr1_data :
                            w_hit0  ? wr0_data :
                                      r_regs[w_raddr[p]];
        assign w_rbusy[p] = w_live & r_busy[w_raddr[p]] & ~(w_hit0 | w_hit1);
    end

    assign rd_data_a = w_rdata[0];
    assign rd_data_b = w_rdata[1];
    assign rd_busy_a = w_rbusy[0];
    assign rd_busy_b = w_rbusy[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
// ============================================================================
// Module   : tb_regfile_bypass_sb
// Brief    : Directed self-checking bench for regfile_bypass_sb (r0 hardwired
//            and ordinary-r0 instances share all inputs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, iss_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        wr0_en, wr1_en, iss_en;

    logic        ready_z, busy_a_z, busy_b_z;
    logic [31:0] data_a_z, data_b_z;
    logic        ready_n, busy_a_n, busy_b_n;
    logic [31:0] data_a_n, data_b_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ready(ready_z),
        .rd_addr_a(rd_addr_a), .rd_data_a(data_a_z), .rd_busy_a(busy_a_z),
        .rd_addr_b(rd_addr_b), .rd_data_b(data_b_z), .rd_busy_b(busy_b_z),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready_n),
        .rd_addr_a(rd_addr_a), .rd_data_a(data_a_n), .rd_busy_a(busy_a_n),
        .rd_addr_b(rd_addr_b), .rd_data_b(data_b_n), .rd_busy_b(busy_b_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    // Counts posedges (from the current negedge) until ready rises; bounded at 40.
    task automatic wait_ready(output int k);
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (ready_z === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int k;
        @(negedge clk); #1;
        n_tests++; if (ready_z !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready_z); end
        n_tests++; if (busy_a_z !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a_z); end
        n_tests++; if (data_a_z !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_a_z); end
        rst = 1'b0;
        wait_ready(k);
        n_tests++; if (k !== 32) begin n_fail++; $display("FAIL sweep_len: ready after %0d posedges want 32", k); end
        n_tests++; if (ready_n !== 1'b1) begin n_fail++; $display("FAIL sweep_len_r0: got %b want 1", ready_n); end
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            rd_addr_a = 5'(a); rd_addr_b = 5'(a);
            #1;
            n_tests++; if (data_a_z !== 32'h0 || data_b_z !== 32'h0) begin
                n_fail++; $display("FAIL sweep_clear r%0d: got %h/%h want 0", a, data_a_z, data_b_z); end
            n_tests++; if (busy_a_z !== 1'b0 || busy_b_z !== 1'b0) begin
                n_fail++; $display("FAIL sweep_busy r%0d: got %b/%b want 0", a, busy_a_z, busy_b_z); end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; rd_addr_a = 5'd5;
        #1;
        n_tests++; if (data_a_z !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_bypass: got %h want deadbeef", data_a_z); end
        @(negedge clk); idle(); #1;
        n_tests++; if (data_a_z !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_array: got %h want deadbeef", data_a_z); end
    endtask

    task automatic test_wr_priority();
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2;
        rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
        n_tests++; if (data_a_z !== 32'h2) begin n_fail++; $display("FAIL t3_bypass_prio_a: got %h want 2", data_a_z); end
        n_tests++; if (data_b_z !== 32'h2) begin n_fail++; $display("FAIL t3_bypass_prio_b: got %h want 2", data_b_z); end
        @(negedge clk); idle(); #1;
        n_tests++; if (data_a_z !== 32'h2) begin n_fail++; $display("FAIL t3_array_prio: got %h want 2", data_a_z); end
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h3;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h4;
        rd_addr_a = 5'd8; rd_addr_b = 5'd9;
        #1;
        n_tests++; if (data_a_z !== 32'h3) begin n_fail++; $display("FAIL t3_bypass_wr0: got %h want 3", data_a_z); end
        n_tests++; if (data_b_z !== 32'h4) begin n_fail++; $display("FAIL t3_bypass_wr1: got %h want 4", data_b_z); end
        @(negedge clk); idle(); #1;
        n_tests++; if (data_a_z !== 32'h3) begin n_fail++; $display("FAIL t3_commit_r8: got %h want 3", data_a_z); end
        n_tests++; if (data_b_z !== 32'h4) begin n_fail++; $display("FAIL t3_commit_r9: got %h want 4", data_b_z); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        #1;
        n_tests++; if (data_a_z !== 32'h0 || busy_a_z !== 1'b0) begin
            n_fail++; $display("FAIL t4_r0_same: got %h busy %b want 0 busy 0", data_a_z, busy_a_z); end
        n_tests++; if (data_a_n !== 32'hFFFFFFFF || busy_a_n !== 1'b0) begin
            n_fail++; $display("FAIL t4_plain_r0_same: got %h busy %b want ffffffff busy 0", data_a_n, busy_a_n); end
        @(negedge clk); idle(); #1;
        n_tests++; if (data_b_z !== 32'h0 || busy_b_z !== 1'b0) begin
            n_fail++; $display("FAIL t4_r0_next: got %h busy %b want 0 busy 0", data_b_z, busy_b_z); end
        n_tests++; if (data_b_n !== 32'hFFFFFFFF || busy_b_n !== 1'b1) begin
            n_fail++; $display("FAIL t4_plain_r0_next: got %h busy %b want ffffffff busy 1", data_b_n, busy_b_n); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        #1;
        n_tests++; if (busy_a_z !== 1'b0) begin n_fail++; $display("FAIL t5_busy_issue_cycle: got %b want 0", busy_a_z); end
        @(negedge clk); idle(); #1;
        n_tests++; if (busy_a_z !== 1'b1 || busy_b_z !== 1'b1) begin
            n_fail++; $display("FAIL t5_busy_set: got %b/%b want 1/1", busy_a_z, busy_b_z); end
        @(negedge clk);
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h55;
        #1;
        n_tests++; if (busy_a_z !== 1'b0 || data_a_z !== 32'h55) begin
            n_fail++; $display("FAIL t5_wb_bypass: got %h busy %b want 55 busy 0", data_a_z, busy_a_z); end
        @(negedge clk); idle(); #1;
        n_tests++; if (busy_a_z !== 1'b0 || data_a_z !== 32'h55) begin
            n_fail++; $display("FAIL t5_cleared: got %h busy %b want 55 busy 0", data_a_z, busy_a_z); end
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd3;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h66;
        #1;
        n_tests++; if (busy_a_z !== 1'b0 || data_a_z !== 32'h66) begin
            n_fail++; $display("FAIL t5_iss_wr_same: got %h busy %b want 66 busy 0", data_a_z, busy_a_z); end
        @(negedge clk); idle(); #1;
        n_tests++; if (busy_a_z !== 1'b1 || data_a_z !== 32'h66) begin
            n_fail++; $display("FAIL t5_new_producer: got %h busy %b want 66 busy 1", data_a_z, busy_a_z); end
    endtask

    task automatic test_init_ignore();
        int k;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h9;
        iss_en = 1'b1; iss_addr = 5'd2;
        rd_addr_a = 5'd2; rd_addr_b = 5'd2;
        #1;
        n_tests++; if (data_a_z !== 32'h0 || busy_a_z !== 1'b0) begin
            n_fail++; $display("FAIL t6_init_read: got %h busy %b want 0 busy 0", data_a_z, busy_a_z); end
        repeat (6) @(negedge clk);
        idle();
        wait_ready(k);
        n_tests++; if (k !== 26) begin n_fail++; $display("FAIL t6_ready_len: ready after %0d more posedges want 26", k); end
        @(negedge clk); #1;
        n_tests++; if (data_a_z !== 32'h0 || busy_a_z !== 1'b0) begin
            n_fail++; $display("FAIL t6_after_init: got %h busy %b want 0 busy 0", data_a_z, busy_a_z); end
    endtask

    task automatic test_reset_mid_run();
        int k;
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h1234;
        iss_en = 1'b1; iss_addr = 5'd11;
        @(negedge clk); idle();
        rd_addr_a = 5'd10; rd_addr_b = 5'd11;
        #1;
        n_tests++; if (data_a_z !== 32'h1234 || busy_b_z !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got %h busy %b want 1234 busy 1", data_a_z, busy_b_z); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ready_z !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", ready_z); end
        @(negedge clk); rst = 1'b0;
        wait_ready(k);
        n_tests++; if (k !== 32) begin n_fail++; $display("FAIL mid_sweep_len: ready after %0d posedges want 32", k); end
        @(negedge clk); #1;
        n_tests++; if (data_a_z !== 32'h0 || busy_b_z !== 1'b0) begin
            n_fail++; $display("FAIL mid_cleared: got %h busy %b want 0 busy 0", data_a_z, busy_b_z); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_bypass();
        test_wr_priority();
        test_zero_reg();
        test_scoreboard();
        test_init_ignore();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
